// File: rtl/poly_eval.sv
// poly_eval: sequential evaluator of Y = (A*X + B)*X +/- C in Horner form.
// The multiplications are done by repeated addition under a down-counter,
// so the datapath is only an adder/subtractor. The result is shown on four
// seven-segment digits.
module poly_eval #(
    parameter int W  = 16,
    parameter int XW = 3,
    parameter int A  = 2,
    parameter int B  = 2,
    parameter int C  = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          mode,
    input  logic [XW-1:0] x,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic [6:0]    d0,
    output logic [6:0]    d1,
    output logic [6:0]    d2,
    output logic [6:0]    d3
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL1 = 3'd2,
        MUL2 = 3'd3,
        DONE = 3'd4
    } state_t;

    // Coefficients are taken modulo 2^W, like all the arithmetic.
    localparam logic [W-1:0] A_W = W'(A);
    localparam logic [W-1:0] B_W = W'(B);
    localparam logic [W-1:0] C_W = W'(C);

    state_t         state_reg;
    state_t         state_next;
    logic [XW-1:0]  x_reg;
    logic           m_reg;
    logic [XW-1:0]  cnt_reg;
    logic [W-1:0]   s_reg;
    logic [W-1:0]   h_reg;
    logic [W-1:0]   result_reg;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: each multiply phase lasts cnt+1 cycles.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = MUL1;
            MUL1:    if (cnt_reg == '0) state_next = MUL2;
            MUL2:    if (cnt_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state alone.
    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
    end

    // Datapath: S accumulates A*X+B, H accumulates S*X, result adds/subtracts C.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_reg      <= '0;
            m_reg      <= 1'b0;
            cnt_reg    <= '0;
            s_reg      <= '0;
            h_reg      <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x_reg <= x;
                        m_reg <= mode;
                    end
                end
                LOAD: begin
                    s_reg   <= '0;
                    cnt_reg <= x_reg;
                end
                MUL1: begin
                    if (cnt_reg != '0) begin
                        s_reg   <= s_reg + A_W;
                        cnt_reg <= cnt_reg - XW'(1);
                    end else begin
                        s_reg   <= s_reg + B_W;
                        h_reg   <= '0;
                        cnt_reg <= x_reg;
                    end
                end
                MUL2: begin
                    if (cnt_reg != '0) begin
                        h_reg   <= h_reg + s_reg;
                        cnt_reg <= cnt_reg - XW'(1);
                    end else if (m_reg) begin
                        result_reg <= h_reg - C_W;
                    end else begin
                        result_reg <= h_reg + C_W;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_reg;

    // Display path: result widened (or truncated) to four hex nibbles.
    logic [15:0] res16;
    generate
        if (W >= 16) begin : g_wide
            assign res16 = result_reg[15:0];
        end else begin : g_narrow
            assign res16 = {{(16-W){1'b0}}, result_reg};
        end
    endgenerate

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [6:0] seg [4];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign seg[gi] = hex_to_seg(res16[gi*4 +: 4]);
        end
    endgenerate

    assign d0 = seg[0];
    assign d1 = seg[1];
    assign d2 = seg[2];
    assign d3 = seg[3];

endmodule

// File: tb/tb_poly_eval.sv
// Testbench for poly_eval: a default instance (W=16) and a W=6 instance
// share all stimulus; results are checked against arithmetic reference values.
module tb_poly_eval;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        mode;
    logic [2:0]  x;
    logic        busy, done;
    logic [15:0] result;
    logic [6:0]  d0, d1, d2, d3;
    logic        busy6, done6;
    logic [5:0]  result6;
    logic [6:0]  e0, e1, e2, e3;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    poly_eval dut (
        .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .x(x),
        .busy(busy), .done(done), .result(result),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3)
    );

    poly_eval #(.W(6)) dut6 (
        .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .x(x),
        .busy(busy6), .done(done6), .result(result6),
        .d0(e0), .d1(e1), .d2(e2), .d3(e3)
    );

    // Reference: 2*x^2 + 2*x +/- 1, reduced modulo 2^w.
    function automatic longint model_y(input int xv, input bit mv, input int w);
        longint y;
        longint mask;
        y = 2 * xv * xv + 2 * xv + (mv ? -1 : 1);
        mask = (longint'(1) << w) - 1;
        return y & mask;
    endfunction

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        return s;
    endfunction

    // One evaluation: pulse start, scramble x/mode after capture, count edges to done.
    task automatic run_eval(input logic [2:0] xv, input logic mv, output int lat,
                            output logic [15:0] r, output logic [5:0] r6, output logic d6);
        @(negedge clock);
        x = xv; mode = mv; start = 1'b1;
        @(posedge clock); #1;
        lat = 1;
        start = 1'b0;
        x = 3'($urandom);
        mode = 1'($urandom);
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        r = result; r6 = result6; d6 = done6;
        @(posedge clock); #1;
        $display("eval x=%0d mode=%0d -> result=%h result6=%h after %0d edges", xv, mv, r, r6, lat);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result: got %h expected 0000", result); end
        checks++; if (result6 !== 6'h0) begin errors++; $display("FAIL reset_result6: got %h expected 00", result6); end
        checks++; if (d0 !== 7'h3F) begin errors++; $display("FAIL reset_d0: got %h expected 3f", d0); end
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_directed;
        int lat; logic [15:0] r; logic [5:0] r6; logic d6;
        run_eval(3'd3, 1'b0, lat, r, r6, d6);
        checks++; if (lat != 10) begin errors++; $display("FAIL x3_latency: got %0d expected 10", lat); end
        checks++; if (r !== 16'h0019) begin errors++; $display("FAIL x3_result: got %h expected 0019", r); end
        checks++; if (d0 !== 7'h6F) begin errors++; $display("FAIL x3_d0: got %h expected 6f", d0); end
        checks++; if (d1 !== 7'h06) begin errors++; $display("FAIL x3_d1: got %h expected 06", d1); end
        checks++; if (d2 !== 7'h3F || d3 !== 7'h3F) begin errors++; $display("FAIL x3_d2d3: got %h %h expected 3f 3f", d2, d3); end
        checks++; if (r6 !== 6'd25) begin errors++; $display("FAIL x3_w6: got %h expected 19", r6); end

        run_eval(3'd3, 1'b1, lat, r, r6, d6);
        checks++; if (r !== 16'h0017) begin errors++; $display("FAIL x3_sub: got %h expected 0017", r); end

        run_eval(3'd0, 1'b1, lat, r, r6, d6);
        checks++; if (lat != 4) begin errors++; $display("FAIL x0_latency: got %0d expected 4", lat); end
        checks++; if (r !== 16'hFFFF) begin errors++; $display("FAIL x0_sub: got %h expected ffff", r); end
        checks++; if (r6 !== 6'h3F) begin errors++; $display("FAIL x0_sub_w6: got %h expected 3f", r6); end
        checks++; if (e0 !== 7'h71 || e1 !== 7'h4F || e2 !== 7'h3F || e3 !== 7'h3F) begin
            errors++; $display("FAIL w6_digits: got %h %h %h %h expected 71 4f 3f 3f", e0, e1, e2, e3);
        end

        run_eval(3'd7, 1'b0, lat, r, r6, d6);
        checks++; if (lat != 18) begin errors++; $display("FAIL x7_latency: got %0d expected 18", lat); end
        checks++; if (r !== 16'd113) begin errors++; $display("FAIL x7_result: got %h expected 0071", r); end
        checks++; if (r6 !== 6'd49 || d6 !== 1'b1) begin errors++; $display("FAIL x7_w6: got %h done=%b expected 31 done=1", r6, d6); end
    endtask

    task automatic test_random;
        int lat; logic [15:0] r; logic [5:0] r6; logic d6;
        logic [2:0] xv; logic mv; logic [15:0] exp16; logic [5:0] exp6;
        for (int i = 0; i < 12; i++) begin
            xv = 3'($urandom_range(0, 7));
            mv = 1'($urandom_range(0, 1));
            exp16 = 16'(model_y(int'(xv), mv, 16));
            exp6  = 6'(model_y(int'(xv), mv, 6));
            run_eval(xv, mv, lat, r, r6, d6);
            checks++; if (lat != 2 * int'(xv) + 4) begin errors++; $display("FAIL rnd_latency x=%0d: got %0d expected %0d", xv, lat, 2 * int'(xv) + 4); end
            checks++; if (r !== exp16) begin errors++; $display("FAIL rnd_result x=%0d m=%0d: got %h expected %h", xv, mv, r, exp16); end
            checks++; if (r6 !== exp6) begin errors++; $display("FAIL rnd_result6 x=%0d m=%0d: got %h expected %h", xv, mv, r6, exp6); end
            checks++; if (d0 !== seg_ref(exp16[3:0]) || d1 !== seg_ref(exp16[7:4]) ||
                          d2 !== seg_ref(exp16[11:8]) || d3 !== seg_ref(exp16[15:12])) begin
                errors++; $display("FAIL rnd_digits %h: got %h %h %h %h", exp16, d3, d2, d1, d0);
            end
        end
    endtask

    task automatic test_ignore;
        int ndone = 0; int dlat = 0; logic [15:0] r = '0;
        int lat; logic [15:0] r2; logic [5:0] r6; logic d6;
        @(negedge clock); x = 3'd5; mode = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        x = 3'd1;
        for (int cyc = 2; cyc <= 40; cyc++) begin
            @(negedge clock);
            start = busy ? ~start : 1'b0;
            @(posedge clock); #1;
            if (done === 1'b1) begin ndone++; dlat = cyc; r = result; end
        end
        start = 1'b0;
        $display("ignore x=5 with start toggling -> %0d done at edge %0d result=%h", ndone, dlat, r);
        checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_count: got %0d expected 1", ndone); end
        checks++; if (dlat != 14) begin errors++; $display("FAIL ignore_latency: got %0d expected 14", dlat); end
        checks++; if (r !== 16'd61) begin errors++; $display("FAIL ignore_result: got %h expected 003d", r); end
        run_eval(3'd1, 1'b0, lat, r2, r6, d6);
        checks++; if (r2 !== 16'd5) begin errors++; $display("FAIL ignore_next: got %h expected 0005", r2); end
    endtask

    task automatic test_abort;
        int seen = 0;
        int lat; logic [15:0] r; logic [5:0] r6; logic d6;
        @(negedge clock); x = 3'd7; mode = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (11) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        $display("abort x=7 in multiply phase -> busy=%b result=%h", busy, result);
        checks++; if (busy !== 1'b0 || busy6 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b %b expected 0 0", busy, busy6); end
        checks++; if (result !== 16'h0) begin errors++; $display("FAIL abort_result: got %h expected 0000", result); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1) seen++;
        end
        @(negedge clock); reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_quiet: got %0d activity cycles expected 0", seen); end
        checks++; if (result !== 16'h0) begin errors++; $display("FAIL abort_hold: got %h expected 0000", result); end
        run_eval(3'd2, 1'b0, lat, r, r6, d6);
        checks++; if (r !== 16'd13 || lat != 8) begin errors++; $display("FAIL abort_restart: got %h in %0d expected 000d in 8", r, lat); end
    endtask

    task automatic test_back_to_back;
        int n = 0; int prev = 0; int first = 0;
        @(negedge clock); x = 3'd1; mode = 1'b0; start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clock); #1;
            if (done === 1'b1) begin
                $display("back_to_back done at edge %0d result=%h", cyc, result);
                checks++; if (result !== 16'd5) begin errors++; $display("FAIL b2b_result: got %h expected 0005", result); end
                if (n == 0) first = cyc;
                else begin
                    checks++; if (cyc - prev != 7) begin errors++; $display("FAIL b2b_period: got %0d expected 7", cyc - prev); end
                end
                prev = cyc;
                n++;
            end
        end
        start = 1'b0;
        checks++; if (first != 6) begin errors++; $display("FAIL b2b_first: got %0d expected 6", first); end
        checks++; if (n != 5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", n); end
        repeat (10) @(posedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        mode = 1'b0;
        x = 3'd0;
        test_reset;
        test_directed;
        test_random;
        test_ignore;
        test_abort;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
